// File: rtl/control_unit_if.sv
// Bus bundle between the control unit and its instruction memory, register file and ALU.
// The master modport is the control unit's view; slave is the environment's view.
interface control_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  logic [2:0]  rf_ra1;
  logic [2:0]  rf_ra2;
  logic [15:0] rf_rd1;
  logic [15:0] rf_rd2;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;

  logic [2:0]  alu_codeop;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_rd;
  logic [15:0] alu_pc;
  logic        alu_ri;
  logic        alu_jmp;
  logic [15:0] alu_r;
  logic        alu_cmp;

  logic [15:0] pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output rf_ra1, rf_ra2, input rf_rd1, rf_rd2,
    output rf_we, rf_wa, rf_wd,
    output alu_codeop, alu_a, alu_b, alu_rd, alu_pc, alu_ri, alu_jmp,
    input alu_r, alu_cmp,
    output pc, halted
  );

  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_rdata,
    input rf_ra1, rf_ra2, output rf_rd1, rf_rd2,
    input rf_we, rf_wa, rf_wd,
    input alu_codeop, alu_a, alu_b, alu_rd, alu_pc, alu_ri, alu_jmp,
    output alu_r, alu_cmp,
    input pc, halted
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for a 16-bit core with R, RI, BR and HALT
// instructions; the ALU and register file live outside and are reached through the bus.
module control_unit (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;

  localparam logic [1:0] T_R  = 2'b00;
  localparam logic [1:0] T_RI = 2'b01;
  localparam logic [1:0] T_BR = 2'b10;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] res_q, res_d;
  logic        cmp_q, cmp_d;

  logic [1:0]  itype;
  logic [2:0]  rd;
  logic [15:0] brOffset;
  logic [2:0]  exCodeop;
  logic [15:0] exA, exB, exRd;
  logic        exRi, exJmp;

  assign itype    = ir_q[15:14];
  assign rd       = ir_q[10:8];
  assign brOffset = {{11{ir_q[4]}}, ir_q[4:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      ir_q    <= 16'h0000;
      opa_q   <= 16'h0000;
      opb_q   <= 16'h0000;
      res_q   <= 16'h0000;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
    end
  end

  // ALU operand selection, built purely from registered state so it is stable through EXEC and WB.
  always_comb begin
    exCodeop = 3'b000;
    exA      = 16'h0000;
    exB      = 16'h0000;
    exRd     = 16'h0000;
    exRi     = 1'b0;
    exJmp    = 1'b0;
    case (itype)
      T_R: begin
        exCodeop = ir_q[13:11];
        exA      = opa_q;
        exB      = opb_q;
      end
      T_RI: begin
        exCodeop = {2'b00, ir_q[11]};
        exA      = {8'h00, ir_q[7:0]};
        exRd     = opa_q;
        exRi     = 1'b1;
      end
      T_BR: begin
        exCodeop = {1'b0, ir_q[12:11]};
        exA      = opa_q;
        exB      = opb_q;
        exJmp    = ir_q[13];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cmp_d   = cmp_q;

    bus.imem_req   = 1'b0;
    bus.imem_addr  = 16'h0000;
    bus.rf_ra1     = 3'd0;
    bus.rf_ra2     = 3'd0;
    bus.rf_we      = 1'b0;
    bus.rf_wa      = 3'd0;
    bus.rf_wd      = 16'h0000;
    bus.alu_codeop = 3'b000;
    bus.alu_a      = 16'h0000;
    bus.alu_b      = 16'h0000;
    bus.alu_rd     = 16'h0000;
    bus.alu_pc     = 16'h0000;
    bus.alu_ri     = 1'b0;
    bus.alu_jmp    = 1'b0;
    bus.pc         = pc_q;
    bus.halted     = 1'b0;

    // Outputs stay quiet while reset is asserted so an in-flight WB write is dropped.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          bus.imem_req  = 1'b1;
          bus.imem_addr = pc_q;
          if (bus.imem_ack) begin
            ir_d    = bus.imem_rdata;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (itype == T_RI) begin
            bus.rf_ra1 = rd;
          end else begin
            bus.rf_ra1 = (itype == T_R) ? ir_q[7:5] : ir_q[10:8];
            bus.rf_ra2 = (itype == T_R) ? ir_q[4:2] : ir_q[7:5];
          end
          opa_d   = bus.rf_rd1;
          opb_d   = bus.rf_rd2;
          state_d = S_EXEC;
        end
        S_EXEC, S_WB: begin
          bus.alu_codeop = exCodeop;
          bus.alu_a      = exA;
          bus.alu_b      = exB;
          bus.alu_rd     = exRd;
          bus.alu_ri     = exRi;
          bus.alu_jmp    = exJmp;
          bus.alu_pc     = pc_q;
          if (state_q == S_EXEC) begin
            res_d   = bus.alu_r;
            cmp_d   = bus.alu_cmp;
            state_d = (itype == 2'b11) ? S_HALT : S_WB;
          end else begin
            pc_d    = pc_q + 16'h0001;
            state_d = S_FETCH;
            if (itype == T_BR) begin
              if (cmp_q) begin
                pc_d = pc_q + brOffset;
                if (ir_q[13]) begin
                  bus.rf_we = 1'b1;
                  bus.rf_wa = 3'd7;
                  bus.rf_wd = res_q;
                end
              end
            end else begin
              bus.rf_we = 1'b1;
              bus.rf_wa = rd;
              bus.rf_wd = res_q;
            end
          end
        end
        S_HALT: begin
          bus.halted = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: behavioural register file and ALU around the DUT,
// one linear instruction sequence with hand-computed expectations.
module tb_control_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycleCount;
  int   startCycle;

  logic [15:0] rf [8] = '{16'h0000, 16'h0000, 16'h0005, 16'h0007,
                          16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] aluR;
  logic        aluCmp;

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Register file: combinational reads, write on the rising edge when strobed.
  assign bus.rf_rd1 = rf[bus.rf_ra1];
  assign bus.rf_rd2 = rf[bus.rf_ra2];
  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_wa] <= bus.rf_wd;
  end

  // ALU: add/sub/and/or/xor for R; mvu/mv for RI; pc+1 on link; compare by cond.
  always_comb begin
    aluR   = 16'h0000;
    aluCmp = 1'b0;
    if (bus.alu_jmp) begin
      aluR = bus.alu_pc + 16'h0001;
    end else if (bus.alu_ri) begin
      aluR = bus.alu_codeop[0] ? {bus.alu_rd[15:8], bus.alu_a[7:0]} : {bus.alu_a[7:0], 8'h00};
    end else begin
      case (bus.alu_codeop)
        3'd0:    aluR = bus.alu_a + bus.alu_b;
        3'd1:    aluR = bus.alu_a - bus.alu_b;
        3'd2:    aluR = bus.alu_a & bus.alu_b;
        3'd3:    aluR = bus.alu_a | bus.alu_b;
        3'd4:    aluR = bus.alu_a ^ bus.alu_b;
        default: aluR = bus.alu_a;
      endcase
    end
    case (bus.alu_codeop[1:0])
      2'b00:   aluCmp = (bus.alu_a == bus.alu_b);
      2'b01:   aluCmp = (bus.alu_a != bus.alu_b);
      2'b10:   aluCmp = (bus.alu_a < bus.alu_b);
      default: aluCmp = (bus.alu_a >= bus.alu_b);
    endcase
  end
  assign bus.alu_r   = aluR;
  assign bus.alu_cmp = aluCmp;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Presents one instruction from the current FETCH cycle after 'waits' unacked cycles;
  // returns in the middle of the DECODE cycle.
  task automatic applyStimulus(input logic [15:0] instr, input int waits, input logic [15:0] expAddr);
    startCycle = cycleCount;
    for (int w = 0; w < waits; w++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'hC000;
      checkOutput("wait_req", 16'(bus.imem_req), 16'h0001);
      checkOutput("wait_addr", bus.imem_addr, expAddr);
      checkOutput("wait_we", 16'(bus.rf_we), 16'h0000);
      nextCycle();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = instr;
    checkOutput("fetch_req", 16'(bus.imem_req), 16'h0001);
    checkOutput("fetch_addr", bus.imem_addr, expAddr);
    nextCycle();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'hC000;
    checkOutput("decode_req", 16'(bus.imem_req), 16'h0000);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    cycleCount     = 0;
    startCycle     = 0;
    rst_n          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'hC000;

    repeat (2) nextCycle();
    #1;
    checkOutput("rst_req", 16'(bus.imem_req), 16'h0000);
    checkOutput("rst_we", 16'(bus.rf_we), 16'h0000);
    checkOutput("rst_halted", 16'(bus.halted), 16'h0000);
    checkOutput("rst_alu_a", bus.alu_a, 16'h0000);
    checkOutput("rst_pc", bus.pc, 16'h0000);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_req", 16'(bus.imem_req), 16'h0001);
    checkOutput("post_rst_addr", bus.imem_addr, 16'h0000);

    // add r1 = r2 + r3 at pc 0, acked immediately
    applyStimulus(16'h014C, 0, 16'h0000);
    checkOutput("add_ra1", 16'(bus.rf_ra1), 16'h0002);
    checkOutput("add_ra2", 16'(bus.rf_ra2), 16'h0003);
    checkOutput("add_dec_alu_a", bus.alu_a, 16'h0000);
    nextCycle();
    checkOutput("add_ex_a", bus.alu_a, 16'h0005);
    checkOutput("add_ex_b", bus.alu_b, 16'h0007);
    checkOutput("add_ex_we", 16'(bus.rf_we), 16'h0000);
    nextCycle();
    checkOutput("add_wb_we", 16'(bus.rf_we), 16'h0001);
    checkOutput("add_wb_wa", 16'(bus.rf_wa), 16'h0001);
    checkOutput("add_wb_wd", bus.rf_wd, 16'h000C);
    checkOutput("add_wb_alu_a", bus.alu_a, 16'h0005);
    nextCycle();
    checkOutput("add_next_addr", bus.imem_addr, 16'h0001);
    checkOutput("add_cycles", 16'(cycleCount - startCycle), 16'h0004);
    checkOutput("add_we_after", 16'(bus.rf_we), 16'h0000);

    // add r4 = r1 + r2 with three wait cycles
    applyStimulus(16'h0428, 3, 16'h0001);
    nextCycle();
    nextCycle();
    checkOutput("wait_wb_wa", 16'(bus.rf_wa), 16'h0004);
    checkOutput("wait_wb_wd", bus.rf_wd, 16'h0011);
    nextCycle();
    checkOutput("wait_pc", bus.pc, 16'h0002);
    checkOutput("wait_cycles", 16'(cycleCount - startCycle), 16'h0007);

    // mvu r2, 0xAB
    applyStimulus(16'h42AB, 0, 16'h0002);
    checkOutput("mvu_ra1", 16'(bus.rf_ra1), 16'h0002);
    nextCycle();
    checkOutput("mvu_ri", 16'(bus.alu_ri), 16'h0001);
    checkOutput("mvu_a", bus.alu_a, 16'h00AB);
    checkOutput("mvu_rd", bus.alu_rd, 16'h0005);
    checkOutput("mvu_op", 16'(bus.alu_codeop), 16'h0000);
    nextCycle();
    checkOutput("mvu_wd", bus.rf_wd, 16'hAB00);
    nextCycle();
    checkOutput("mvu_r2", rf[2], 16'hAB00);

    // mv r2, 0x01
    applyStimulus(16'h4A01, 0, 16'h0003);
    nextCycle();
    checkOutput("mv_op", 16'(bus.alu_codeop), 16'h0001);
    checkOutput("mv_rd", bus.alu_rd, 16'hAB00);
    nextCycle();
    nextCycle();
    checkOutput("mv_r2", rf[2], 16'hAB01);
    checkOutput("mv_pc", bus.pc, 16'h0004);

    // beq r0, r0, +12 -> 0x0010
    applyStimulus(16'h800C, 0, 16'h0004);
    nextCycle();
    nextCycle();
    checkOutput("br_fwd_we", 16'(bus.rf_we), 16'h0000);
    nextCycle();
    checkOutput("br_fwd_pc", bus.pc, 16'h0010);

    // link branch with unequal operands falls through
    applyStimulus(16'hA15E, 0, 16'h0010);
    nextCycle();
    checkOutput("br_ne_jmp", 16'(bus.alu_jmp), 16'h0001);
    nextCycle();
    checkOutput("br_ne_we", 16'(bus.rf_we), 16'h0000);
    nextCycle();
    checkOutput("br_ne_pc", bus.pc, 16'h0011);

    // beq r0, r0, -1 back to 0x0010
    applyStimulus(16'h801F, 0, 16'h0011);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("br_back_pc", bus.pc, 16'h0010);

    // link branch with equal operands, offset -2
    applyStimulus(16'hA25E, 0, 16'h0010);
    nextCycle();
    checkOutput("br_eq_alu_pc", bus.alu_pc, 16'h0010);
    nextCycle();
    checkOutput("br_eq_we", 16'(bus.rf_we), 16'h0001);
    checkOutput("br_eq_wa", 16'(bus.rf_wa), 16'h0007);
    checkOutput("br_eq_wd", bus.rf_wd, 16'h0011);
    nextCycle();
    checkOutput("br_eq_pc", bus.pc, 16'h000E);
    checkOutput("br_eq_r7", rf[7], 16'h0011);

    // add r5 = r1 + r1, reset asserted in WB
    applyStimulus(16'h0524, 0, 16'h000E);
    nextCycle();
    nextCycle();
    checkOutput("abort_wb_we", 16'(bus.rf_we), 16'h0001);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we_gated", 16'(bus.rf_we), 16'h0000);
    nextCycle();
    checkOutput("abort_r5", rf[5], 16'h0000);
    checkOutput("abort_pc", bus.pc, 16'h0000);
    checkOutput("abort_req", 16'(bus.imem_req), 16'h0000);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_fetch_req", 16'(bus.imem_req), 16'h0001);
    checkOutput("abort_fetch_addr", bus.imem_addr, 16'h0000);

    // beq r0, r0, -1 from pc 0 -> 0xFFFF, then add wraps pc to 0
    applyStimulus(16'h801F, 0, 16'h0000);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("wrap_neg_pc", bus.pc, 16'hFFFF);
    applyStimulus(16'h064C, 0, 16'hFFFF);
    nextCycle();
    nextCycle();
    checkOutput("wrap_wd", bus.rf_wd, 16'hAB08);
    nextCycle();
    checkOutput("wrap_pc", bus.pc, 16'h0000);

    // HALT with a stray ack held high
    applyStimulus(16'hC000, 0, 16'h0000);
    nextCycle();
    nextCycle();
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("halt_halted", 16'(bus.halted), 16'h0001);
      checkOutput("halt_req", 16'(bus.imem_req), 16'h0000);
      checkOutput("halt_we", 16'(bus.rf_we), 16'h0000);
      checkOutput("halt_alu_a", bus.alu_a, 16'h0000);
      nextCycle();
    end
    checkOutput("halt_pc", bus.pc, 16'h0000);
    bus.imem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock, `clk`, and reset SHALL be synchronous and active-low on `rst_n`.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  16  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  fetched instruction
- rf_ra1, rf_ra2  out  3 each  register-file read addresses
- rf_rd1, rf_rd2  in  16 each  read data, combinational from ra1/ra2
- rf_we  out  1  register write strobe
- rf_wa  out  3  write address
- rf_wd  out  16  write data
- alu_codeop  out  3  ALU operation
- alu_a, alu_b, alu_rd, alu_pc  out  16 each  ALU operands
- alu_ri  out  1  immediate-class select
- alu_jmp  out  1  link select (ALU returns pc+1)
- alu_r  in  16  ALU result
- alu_cmp  in  1  ALU compare result
- pc  out  16  architectural program counter
- halted  out  1  high in HALT state

Function
REQ-003 Instruction type SHALL be instr[15:14]: 00 R, 01 RI, 10 BR, 11 HALT.
REQ-004 Field layouts SHALL be:
- R: [13:11] codeop, [10:8] rd, [7:5] rs1, [4:2] rs2.
- RI: [11] mv(1)/mvu(0), [10:8] rd, [7:0] imm8.
- BR: [13] link, [12:11] cond, [10:8] rs1, [7:5] rs2, [4:0] signed offset.
REQ-005 FSM states SHALL be FETCH, DECODE, EXEC, WB, HALT; transitions:
- FETCH->DECODE on imem_ack; otherwise stay in FETCH.
- DECODE->EXEC.
- EXEC->WB, or EXEC->HALT for type 11.
- WB->FETCH.
- HALT->HALT until reset.
REQ-006 In FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack; the instruction register SHALL latch imem_rdata on the ack cycle.
REQ-007 imem_req SHALL be 0 in all states other than FETCH, and imem_ack SHALL be ignored outside FETCH.
REQ-008 DECODE SHALL drive rf_ra1/rf_ra2:
- R: rs1/rs2.
- RI: rd/don't-care.
- BR: rs1/rs2.
REQ-009 DECODE SHALL register rf_rd1/rf_rd2 into operand registers opA/opB at the end of the cycle.
REQ-010 EXEC SHALL drive the ALU from registered values only:
- R: codeop=[13:11], a=opA, b=opB, rd=0, ri=0, jmp=0.
- RI: codeop={2'b00,[11]}, a={8'h00,imm8}, b=0, rd=opA, ri=1, jmp=0.
- BR: codeop={1'b0,cond}, a=opA, b=opB, ri=0, jmp=link.
- alu_pc=pc in all cases.
REQ-011 alu_r and alu_cmp SHALL be registered at the end of EXEC.
REQ-012 ALU outputs SHALL be held at the values from REQ-010 in WB and be 0 in FETCH/DECODE/HALT.
REQ-013 WB for R and RI SHALL assert rf_we=1 for exactly one cycle with rf_wa=rd and rf_wd=the registered alu_r, then set pc<=pc+1.
REQ-014 WB for BR with registered cmp=1 SHALL set pc<=pc+sext(offset); with cmp=0 it SHALL set pc<=pc+1.
REQ-015 WB for BR with link=1 and cmp=1 SHALL write the registered alu_r (pc+1) to r7; with link=0 or cmp=0, rf_we SHALL be 0.
REQ-016 All pc arithmetic SHALL be modulo 2^16 (0xFFFF+1=0x0000).
REQ-017 With imem_ack=1 in the first FETCH cycle, each instruction SHALL take exactly 4 cycles; each wait cycle SHALL add 1.
REQ-018 rf_we SHALL be 0 outside WB.
REQ-019 HALT SHALL assert halted=1 and perform no fetches or writes.

Reset
REQ-020 While rst_n=0 at a rising edge, the next state SHALL be FETCH with pc=0x0000 and instruction/operand/result registers cleared.
REQ-021 Reset values SHALL be: imem_req=0, rf_we=0, halted=0, all ALU outputs 0.
REQ-022 Reset SHALL take priority in any state, including mid-FETCH with imem_ack=1 and during a WB write, and that write SHALL be suppressed.
REQ-023 In the first cycle after rst_n rises, the FSM SHALL be in FETCH with imem_req=1 and imem_addr=0x0000.

Verification
REQ-024 A bench SHALL cover:
- Reset, then ack every fetch; mem[0]=R add r1=r2+r3 with r2=5, r3=7 -> cycle 4: rf_we=1, rf_wa=1, rf_wd=12; next fetch at pc=1.
- Ack delayed 3 cycles -> imem_req and imem_addr held; instruction completes in 7 cycles; no early rf_we.
- RI mvu rd=2, imm8=0xAB, then mv rd=2, imm8=0x01 -> r2=0xAB00, then r2=0xAB01.
- BR cond=00, rs1=rs2, offset=-2, link=1 at pc=0x0010 -> pc=0x000E, r7=0x0011; with unequal operands -> pc=0x0011, rf_we=0.
- pc=0xFFFF, R instruction -> pc wraps to 0x0000.
- HALT -> halted=1, imem_req=0 forever.
- rst_n low during WB -> no write occurs; pc=0x0000; FETCH follows.
